// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the reset domains it releases.
// The sequencer uses the slave modport; the environment drives acks and restarts through master.
interface reset_sequencer_if #(
   parameter int NUM_STAGES = 4
);
   logic [NUM_STAGES-1:0] stage_ack_i;
   logic                  sw_rst_req_i;
   logic [NUM_STAGES-1:0] rst_o;
   logic                  all_done_o;
   logic                  timeout_o;

   modport master (
      output stage_ack_i,
      output sw_rst_req_i,
      input  rst_o,
      input  all_done_o,
      input  timeout_o
   );

   modport slave (
      input  stage_ack_i,
      input  sw_rst_req_i,
      output rst_o,
      output all_done_o,
      output timeout_o
   );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order after a hold period, waiting for each stage's ack
// (bounded by an optional timeout) plus a fixed gap before releasing the next one.
module reset_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int MIN_HOLD    = 16,
   parameter int STAGE_DLY   = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    async_rst_i,
   reset_sequencer_if.slave        bus
);
   localparam int MAX_A = (MIN_HOLD > STAGE_DLY) ? MIN_HOLD : STAGE_DLY;
   localparam int MAXV  = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
   localparam int CW    = $clog2(MAXV + 1);
   localparam int IW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
   localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
   localparam logic [CW-1:0] TO_LAST   = (ACK_TIMEOUT == 0) ? '0 : CW'(ACK_TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT_ACK,
      S_DLY,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_STAGES-1:0]  rst_q, rst_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;

   logic [CW-1:0]          cnt_inc;
   logic                   ack_sel;
   logic                   timeout_hit;

   always_ff @(posedge clk or posedge async_rst_i) begin
      if (async_rst_i) begin
         state_q   <= S_HOLD;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_q     <= '1;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_q     <= rst_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   // Counter saturates rather than wrapping; it is cleared on every state change.
   assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign ack_sel     = bus.stage_ack_i[idx_q];
   assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_d     = rst_q;
      done_d    = done_q;
      timeout_d = timeout_q;

      if (bus.sw_rst_req_i) begin
         // Software restart keeps the sticky timeout flag.
         state_d = S_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '1;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_d[0] = 1'b0;
                  state_d  = S_WAIT_ACK;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_WAIT_ACK: begin
               if (ack_sel || timeout_hit) begin
                  if (!ack_sel) begin
                     timeout_d = 1'b1;
                  end
                  cnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_DLY;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_DLY: begin
               if (cnt_q == DLY_LAST) begin
                  idx_d        = idx_q + 1'b1;
                  rst_d[idx_d] = 1'b0;
                  state_d      = S_WAIT_ACK;
                  cnt_d        = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_DONE: begin
               rst_d  = '0;
               done_d = 1'b1;
            end
            default: begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign bus.rst_o      = rst_q;
   assign bus.all_done_o = done_q;
   assign bus.timeout_o  = timeout_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scenarios followed by randomized acks/restarts/resets, every cycle checked
// against an edge-timestamp reference model of the release schedule.
module tb_reset_sequencer;
   localparam int N  = 4;
   localparam int MH = 16;
   localparam int SD = 8;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic async_rst = 1'b0;

   reset_sequencer_if #(.NUM_STAGES(N)) bus ();

   reset_sequencer #(
      .NUM_STAGES (N),
      .MIN_HOLD   (MH),
      .STAGE_DLY  (SD),
      .ACK_TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .async_rst_i(async_rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: absolute edge numbers for the next release and the start of an ack wait.
   int         edge_n = 0;
   logic [N-1:0] m_rst = '1;
   logic       m_done = 1'b0;
   logic       m_to   = 1'b0;
   int         k       = 0;
   bit         waiting = 0;
   int         w0      = 0;
   int         rel_at  = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".rst_o"}, 32'(bus.rst_o), 32'(m_rst));
      check({tag, ".all_done_o"}, 32'(bus.all_done_o), 32'(m_done));
      check({tag, ".timeout_o"}, 32'(bus.timeout_o), 32'(m_to));
   endtask

   task automatic model_reset();
      m_rst   = '1;
      m_done  = 1'b0;
      m_to    = 1'b0;
      k       = 0;
      waiting = 0;
      rel_at  = -1;
   endtask

   task automatic model_step();
      logic ack;
      edge_n++;
      if (async_rst) return;
      if (bus.sw_rst_req_i) begin
         m_rst   = '1;
         m_done  = 1'b0;
         k       = 0;
         waiting = 0;
         rel_at  = edge_n + MH;
      end else if (waiting) begin
         ack = bus.stage_ack_i[k-1];
         if (!ack && TO != 0 && (edge_n - w0) == TO) begin
            m_to = 1'b1;
            ack  = 1'b1;
         end
         if (ack) begin
            waiting = 0;
            if (k == N) m_done = 1'b1;
            else        rel_at = edge_n + SD;
         end
      end else if (k < N && edge_n == rel_at) begin
         m_rst[k] = 1'b0;
         k++;
         waiting = 1;
         w0      = edge_n;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs("cycle");
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   // Called 1 ns after an edge; asserts reset between edges and checks the immediate effect.
   task automatic assert_async();
      #3;
      async_rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_assert");
   endtask

   task automatic release_async();
      async_rst = 1'b0;
      rel_at    = edge_n + MH;
   endtask

   task automatic sw_pulse();
      bus.sw_rst_req_i = 1'b1;
      cycle();
      bus.sw_rst_req_i = 1'b0;
   endtask

   logic [N-1:0] mask;

   initial begin
      bus.stage_ack_i  = '1;
      bus.sw_rst_req_i = 1'b0;
      #2;
      async_rst = 1'b1;
      #1;
      model_reset();
      check_outputs("reset");
      run(2);
      release_async();

      // Acks tied high: nominal release schedule
      run(50);

      // Async reset mid-sequence, after stage 1 released
      assert_async();
      run(2);
      release_async();
      run(30);
      assert_async();
      run(1);
      release_async();
      run(50);

      // Stage 1 ack held low for a while
      assert_async();
      run(1);
      release_async();
      bus.stage_ack_i = 4'hD;
      run(MH + SD + 1 + 20);
      bus.stage_ack_i = 4'hF;
      run(40);

      // Stage 2 ack stuck low: timeout, sequence completes, flag survives restart
      bus.stage_ack_i = 4'hB;
      sw_pulse();
      run(MH + 2 * (SD + 1) + TO + SD + 10);
      sw_pulse();
      run(30);
      bus.stage_ack_i = 4'hF;
      run(60);

      // Software restart from DONE
      sw_pulse();
      run(50);

      // Short async pulse during the hold count
      assert_async();
      run(1);
      release_async();
      run(10);
      assert_async();
      run(1);
      release_async();
      run(50);

      // Randomized acks, restarts and resets
      mask = '1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) mask = N'($urandom_range(0, (1 << N) - 1)) | N'($urandom_range(0, (1 << N) - 1));
         bus.stage_ack_i = N'($urandom) & mask;
         if ($urandom_range(0, 499) == 0) begin
            assert_async();
            run($urandom_range(0, 2));
            release_async();
         end else if ($urandom_range(0, 149) == 0) begin
            sw_pulse();
         end else begin
            cycle();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
